// File: rtl/sched_pkg.sv
// Shared types and constants for the millisecond event scheduler.
package sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int unsigned DIV_DEFAULT = 25175;
  localparam int unsigned NCH_DEFAULT = 4;

  // cfg_arm encodings
  localparam logic ARM    = 1'b1;
  localparam logic DISARM = 1'b0;

endpackage

// File: rtl/ms_event_scheduler_if.sv
// Channel configuration handshake between a requester and the scheduler.
interface ms_event_scheduler_if #(
  parameter int unsigned CW = 2,
  parameter int unsigned PW = 16
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic          cfg_arm;
  logic          cfg_periodic;
  logic [PW-1:0] cfg_period;

  modport master (
    output cfg_valid, cfg_ch, cfg_arm, cfg_periodic, cfg_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_arm, cfg_periodic, cfg_period,
    output cfg_ready
  );

endinterface

// File: rtl/ms_prescaler.sv
// Divides clk_in into a single-cycle enable strobe every DIV cycles.
module ms_prescaler #(
  parameter int unsigned DIV = 25175
) (
  input  logic clk_in,
  input  logic reset_n,
  output logic ms_tick
);

  localparam int unsigned CNTW = $clog2(DIV);

  logic [CNTW-1:0] pre_cnt;

  // Wrap counter; the strobe is registered one count early so it is high
  // exactly while pre_cnt sits at DIV-1.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      ms_tick <= 1'b0;
    end else begin
      if (pre_cnt == CNTW'(DIV - 1)) pre_cnt <= '0;
      else                           pre_cnt <= pre_cnt + CNTW'(1);
      ms_tick <= (pre_cnt == CNTW'(DIV - 2));
    end
  end

endmodule

// File: rtl/ms_event_scheduler.sv
// Millisecond event scheduler: one shared decrementer scans NCH timer
// channels once per ms tick and pulses an event on each expiry.
module ms_event_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned PW  = 16,
  parameter int unsigned CW  = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  ms_event_scheduler_if.slave  cfg,
  output logic                 ms_tick,
  output logic                 busy,
  output logic [NCH-1:0]       active,
  output logic [NCH-1:0]       events
);

  state_t        state, state_nx;
  logic [CW-1:0] idx, idx_nx;
  logic [PW-1:0] remaining [NCH];
  logic [PW-1:0] period    [NCH];
  logic [NCH-1:0] periodic;
  logic          cfg_fire;
  logic          cur_active;
  logic [PW-1:0] cur_rem;
  logic [PW-1:0] dec;

  ms_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .ms_tick (ms_tick)
  );

  // Config is only taken while idle and not ticking, so writes never race a scan.
  assign cfg.cfg_ready = reset_n && (state == IDLE) && !ms_tick;
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

  // Shared decrementer operates on the channel selected by idx.
  assign cur_active = active[idx];
  assign cur_rem    = remaining[idx];
  assign dec        = cur_rem - PW'(1);

  // State register; busy mirrors the SCAN state.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      busy  <= (state_nx == SCAN);
    end
  end

  // Next-state: a tick starts a scan of NCH consecutive channels.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (ms_tick) begin
          state_nx = SCAN;
          idx_nx   = '0;
        end
      end
      SCAN: begin
        if (idx == CW'(NCH - 1)) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // Channel state: config writes in IDLE, countdown and expiry in SCAN.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        remaining[i] <= '0;
        period[i]    <= '0;
      end
      periodic <= '0;
      active   <= '0;
      events   <= '0;
    end else begin
      events <= '0;
      if (cfg_fire) begin
        if ((cfg.cfg_arm == ARM) && (cfg.cfg_period != '0)) begin
          period[cfg.cfg_ch]    <= cfg.cfg_period;
          remaining[cfg.cfg_ch] <= cfg.cfg_period;
          periodic[cfg.cfg_ch]  <= cfg.cfg_periodic;
          active[cfg.cfg_ch]    <= 1'b1;
        end else begin
          // Disarm, or arm with a zero period: cancel any pending expiry.
          remaining[cfg.cfg_ch] <= '0;
          active[cfg.cfg_ch]    <= 1'b0;
        end
      end else if ((state == SCAN) && cur_active) begin
        if (cur_rem == PW'(1)) begin
          events[idx] <= 1'b1;
          if (periodic[idx]) begin
            remaining[idx] <= period[idx];
          end else begin
            remaining[idx] <= '0;
            active[idx]    <= 1'b0;
          end
        end else begin
          remaining[idx] <= dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_event_scheduler.sv
// Directed bench for ms_event_scheduler with DIV=10, NCH=4, PW=16.
// cyc counts rising edges since reset release; ticks land on cyc 9, 19, 29, ...
module tb_ms_event_scheduler;

  localparam int unsigned DIV = 10;
  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = 16;
  localparam int unsigned CW  = 2;

  logic           clk;
  logic           reset_n;
  logic           ms_tick;
  logic           busy;
  logic [NCH-1:0] active;
  logic [NCH-1:0] events;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ev_cnt [NCH];
  int multi_hot = 0;
  int ev0_snap  = 0;

  ms_event_scheduler_if #(.CW(CW), .PW(PW)) cfg_if ();

  ms_event_scheduler #(.DIV(DIV), .NCH(NCH), .PW(PW), .CW(CW)) dut (
    .clk_in  (clk),
    .reset_n (reset_n),
    .cfg     (cfg_if),
    .ms_tick (ms_tick),
    .busy    (busy),
    .active  (active),
    .events  (events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Tally event pulses per channel and any multi-hot event vector.
  initial for (int k = 0; k < NCH; k++) ev_cnt[k] = 0;
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) if (events[k]) ev_cnt[k] <= ev_cnt[k] + 1;
    if ($countones(events) > 1) multi_hot <= multi_hot + 1;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the rising edge that makes cyc == c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [CW-1:0] ch, input logic arm, input logic per,
                       input logic [PW-1:0] p);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_ch       = ch;
    cfg_if.cfg_arm      = arm;
    cfg_if.cfg_periodic = per;
    cfg_if.cfg_period   = p;
  endtask

  task automatic release_cfg();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_ch       = '0;
    cfg_if.cfg_arm      = 1'b0;
    cfg_if.cfg_periodic = 1'b0;
    cfg_if.cfg_period   = '0;

    // Reset values.
    #12;
    chk("rst_tick",   32'(ms_tick), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_events", 32'(events), 32'd0);
    chk("rst_ready",  32'(cfg_if.cfg_ready), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", 32'(cfg_if.cfg_ready), 32'd1);

    // Free-running prescaler and empty scans.
    goto(8);  chk("tick_c8",   32'(ms_tick), 32'd0);
    goto(9);  chk("tick_c9",   32'(ms_tick), 32'd1);
              chk("ready_c9",  32'(cfg_if.cfg_ready), 32'd0);
    goto(10); chk("tick_c10",  32'(ms_tick), 32'd0);
              chk("busy_c10",  32'(busy), 32'd1);
    goto(13); chk("busy_c13",  32'(busy), 32'd1);
    goto(14); chk("busy_c14",  32'(busy), 32'd0);
              chk("ready_c14", 32'(cfg_if.cfg_ready), 32'd1);
    goto(18); chk("tick_c18",  32'(ms_tick), 32'd0);
    goto(19); chk("tick_c19",  32'(ms_tick), 32'd1);

    // ch2 one-shot P=3 accepted at edge 25; fires at tick 49 + 4 = cyc 53.
    goto(24); chk("ready_c24", 32'(cfg_if.cfg_ready), 32'd1);
    drive(2'd2, 1'b1, 1'b0, 16'd3);
    goto(25); release_cfg();
    chk("arm2_active", 32'(active), 32'h4);
    goto(52); chk("ch2_c52_ev", 32'(events), 32'h0);
              chk("ch2_c52_act", 32'(active), 32'h4);
    goto(53); chk("ch2_c53_ev", 32'(events), 32'h4);
              chk("ch2_c53_act", 32'(active), 32'h0);
    goto(54); chk("ch2_c54_ev", 32'(events), 32'h0);

    // ch0 periodic P=1 (edge 55), ch3 periodic P=2 (edge 56).
    drive(2'd0, 1'b1, 1'b1, 16'd1);
    goto(55); drive(2'd3, 1'b1, 1'b1, 16'd2);
    goto(56); release_cfg();
    chk("per_active", 32'(active), 32'h9);
    goto(61); chk("p_c61", 32'(events), 32'h1);
    goto(62); chk("p_c62", 32'(events), 32'h0);
    goto(64); chk("p_c64", 32'(events), 32'h0);
    goto(71); chk("p_c71", 32'(events), 32'h1);
    goto(74); chk("p_c74", 32'(events), 32'h8);
    goto(75); chk("p_c75", 32'(events), 32'h0);
    goto(81); chk("p_c81", 32'(events), 32'h1);
    goto(84); chk("p_c84", 32'(events), 32'h0);
    goto(91); chk("p_c91", 32'(events), 32'h1);
    goto(94); chk("p_c94", 32'(events), 32'h8);

    // Request raised on the tick: held off through the scan, taken at cyc 104.
    goto(99);
    drive(2'd1, 1'b1, 1'b0, 16'd5);
    chk("hold_r99", 32'(cfg_if.cfg_ready), 32'd0);
    goto(100); chk("hold_r100", 32'(cfg_if.cfg_ready), 32'd0);
    goto(101); chk("hold_r101", 32'(cfg_if.cfg_ready), 32'd0);
    goto(102); chk("hold_r102", 32'(cfg_if.cfg_ready), 32'd0);
    goto(103); chk("hold_r103", 32'(cfg_if.cfg_ready), 32'd0);
    goto(104); chk("hold_r104", 32'(cfg_if.cfg_ready), 32'd1);
               chk("hold_act104", 32'(active), 32'h9);
    goto(105); release_cfg();
    chk("hold_act105", 32'(active), 32'hB);

    // ch1 reaches remaining==1 after four ticks; disarm it at cyc 144.
    goto(144);
    chk("dis_act144", 32'(active), 32'hB);
    drive(2'd1, 1'b0, 1'b0, 16'd5);
    goto(145); release_cfg();
    chk("dis_act145", 32'(active), 32'h9);
    goto(152); chk("dis_ev152", 32'(events), 32'h0);

    // Arm with period zero behaves as a disarm.
    goto(155);
    drive(2'd1, 1'b1, 1'b0, 16'd0);
    goto(156); release_cfg();
    chk("p0_act156", 32'(active), 32'h9);
    goto(175); chk("ch1_count", 32'(ev_cnt[1]), 32'd0);

    // Reset mid-scan while ch0 sits at remaining==1 (would fire at cyc 181).
    goto(180);
    chk("mid_busy180", 32'(busy), 32'd1);
    ev0_snap = ev_cnt[0];
    chk("ch0_count", 32'(ev0_snap), 32'd12);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_tick",   32'(ms_tick), 32'd0);
    chk("ar_busy",   32'(busy), 32'd0);
    chk("ar_active", 32'(active), 32'd0);
    chk("ar_events", 32'(events), 32'd0);
    chk("ar_ready",  32'(cfg_if.cfg_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    goto(2);  chk("post_ev", 32'(events), 32'h0);
    goto(8);  chk("post_tick8", 32'(ms_tick), 32'd0);
    goto(9);  chk("post_tick9", 32'(ms_tick), 32'd1);
    goto(12);
    chk("post_ch0_count", 32'(ev_cnt[0]), 32'd12);
    chk("ch2_count",      32'(ev_cnt[2]), 32'd1);
    chk("ch3_count",      32'(ev_cnt[3]), 32'd6);
    chk("ch1_final",      32'(ev_cnt[1]), 32'd0);
    chk("no_concurrent",  32'(multi_hot), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
